sha256_msg_padder: RTL and testbench
====================================

# sha256_msg_padder

Upstream stage of the SHA-256 chunk compressor. Accepts a message as a byte stream with valid/ready/last, packs bytes big-endian into 512-bit blocks, and applies standard SHA-256 padding: a 0x80 marker, zero fill, and a 64-bit big-endian bit length. Each completed block is presented on a valid/ready chunk port that feeds the compressor's `chunk`/`valid`/`ready` directly. `chunk_last` tells the host controller where a message ends.

## Interface
- `LEN_W`, default 61: width of the byte-length counter. Bit length = {count, 3'b0}, zero-extended to 64 bits.
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `in_data`  in  8  message byte
- `in_valid`  in  1  `in_data` valid
- `in_last`  in  1  qualifies the final byte of the message
- `in_ready`  out  1  byte accepted when `in_valid && in_ready`
- `chunk`  out  512  block; message byte 0 is at [511:504]
- `chunk_valid`  out  1  `chunk` valid
- `chunk_ready`  in  1  block consumed when `chunk_valid && chunk_ready`
- `chunk_last`  out  1  block is the final block of its message; valid with `chunk_valid`
- `chunk_count`  out  32  blocks emitted since reset (only when the macro is defined)

## Operation
- State FILL (reset state): `in_ready`=1.
  - Each accepted byte is written at buffer position p (byte p is at [511-8p -: 8]); then p++ and len++.
  - If p reaches 64: go to EMIT with `chunk_last`=0. Return state is PAD if `in_last`, else FILL.
  - If `in_last` and p<64: go to PAD.
- State PAD:
  - Writes 0x80 at position p and zeroes positions p+1..63.
  - If p≤55: writes len·8 into [63:0], `chunk_last`=1, go to EMIT, return state FILL.
  - If p≥56: `chunk_last`=0, go to EMIT, return state LEN.
- State LEN: buffer = all zero except [63:0] = len·8; `chunk_last`=1; go to EMIT, return state FILL.
- State EMIT:
  - `chunk_valid`=1 and `in_ready`=0.
  - On handshake: p←0 and go to the return state.
  - On entry to FILL from a final block: len←0 and the buffer is cleared.
- Bytes beyond the final one are never accepted until the final block completes its handshake.
- Zero-length messages are not supported; every message carries at least one byte with `in_last`.
- len wraps modulo 2^LEN_W with no error.
- Reset values:
  - state FILL, p=0, len=0, buffer=0
  - `chunk_valid`=0, `chunk_last`=0, `in_ready`=1 from the first cycle after reset
  - `chunk_count`=0
- Reset mid-message or mid-EMIT discards all partial state; no block is emitted.

## Timing
- Input throughput: 1 byte/cycle in FILL. 64 data bytes take 64 cycles plus at least 1 EMIT cycle.
- `chunk_valid` rises on the cycle after the 64th byte is accepted. If the last byte leaves p<64, it rises 2 cycles after that byte is accepted (PAD, then EMIT).
- A two-block tail adds 1 LEN cycle after the first tail block's handshake.
- While `chunk_valid`=1 and `chunk_ready`=0, `chunk` and `chunk_last` are held stable. `chunk_valid` never deasserts without a handshake.
- `chunk_valid` has no combinational dependence on `chunk_ready`; `in_ready` has no combinational dependence on `in_valid`.

## Configuration
- `SHA256_PADDER_STATS_EN`:
  - Defined: `chunk_count` port exists and increments by 1 on every chunk handshake, wrapping at 2^32.
  - Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- `sha256_pkg` holds:
  - `chunk_t` (logic [511:0])
  - padder state enum {FILL, PAD, LEN, EMIT}
  - constants BLOCK_BYTES=64, LEN_POS=56, PAD_BYTE=8'h80
- Sub-module `sha256_pad_mask` (combinational): given buffer, p and bit length, returns the padded block and a `needs_extra` flag. PAD and LEN both use it.

## Test plan
- "abc" (0x61,0x62,0x63, last on 0x63) -> one block `61626380`, then zeros, [63:0]=0x18, `chunk_last`=1. Compressor output = ba7816bf…f20015ad.
- 55 bytes of 0x00 -> one block with byte 55=0x80, [63:0]=0x1B8, `chunk_last`=1.
- 56 bytes of 0x41 -> two blocks. Block 1: byte 56=0x80, zeros to the end, `chunk_last`=0. Block 2: all zero, [63:0]=0x1C0, `chunk_last`=1.
- 64 bytes -> block 1 = raw data, `chunk_last`=0. Block 2: byte 0=0x80, [63:0]=0x200, `chunk_last`=1. Then a second message "abc" yields [63:0]=0x18, showing the length was cleared.
- Hold `chunk_ready`=0 for 10 cycles during EMIT -> `chunk` stable, `in_ready`=0, `chunk_valid`=1 throughout. Release -> exactly one handshake.
- Assert reset after 30 bytes -> no block emitted, `in_ready`=1 next cycle. A fresh "abc" then produces the correct single block, and `chunk_count` (macro defined) = 1.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message padder.
package sha256_pkg;

  typedef logic [511:0] chunk_t;

  typedef enum logic [1:0] {
    FILL,
    PAD,
    LEN,
    EMIT
  } pad_state_t;

  localparam int         BLOCK_BYTES = 64;
  localparam int         LEN_POS     = 56;
  localparam logic [7:0] PAD_BYTE    = 8'h80;

endpackage

// File: rtl/sha256_pad_mask.sv
// Combinational SHA-256 padding of a partial block: keeps bytes below pos, adds the
// 0x80 marker, zero fill and (when it fits) the 64-bit length. len_only gives a length-only block.
module sha256_pad_mask
  import sha256_pkg::*;
(
  input  chunk_t      blk,
  input  logic [6:0]  pos,
  input  logic [63:0] bit_len,
  input  logic        len_only,
  output chunk_t      padded,
  output logic        needs_extra
);

  logic len_fits;

  assign needs_extra = !len_only && (pos >= 7'(LEN_POS));
  assign len_fits    = !needs_extra;

  for (genvar gi = 0; gi < BLOCK_BYTES; gi++) begin : g_lane
    localparam int HI = 511 - 8 * gi;
    logic [7:0] data_byte;

    always_comb begin
      data_byte = 8'h00;
      if (!len_only) begin
        if (7'(gi) < pos) begin
          data_byte = blk[HI -: 8];
        end else if (7'(gi) == pos) begin
          data_byte = PAD_BYTE;
        end
      end
    end

    // The last eight lanes carry the bit length unless the marker spilled into them.
    if (gi >= LEN_POS) begin : g_len_lane
      assign padded[HI -: 8] = len_fits ? bit_len[HI -: 8] : data_byte;
    end else begin : g_data_lane
      assign padded[HI -: 8] = data_byte;
    end
  end

endmodule

// File: rtl/sha256_msg_padder.sv
// Byte-stream to padded 512-bit SHA-256 block packer with valid/ready on both sides.
// Define SHA256_PADDER_STATS_EN to add the chunk_count handshake counter port.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 61
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [511:0] chunk,
  output logic         chunk_valid,
  input  logic         chunk_ready,
  output logic         chunk_last
`ifdef SHA256_PADDER_STATS_EN
  ,
  output logic [31:0]  chunk_count
`endif
);

  pad_state_t       state_reg;
  pad_state_t       ret_reg;
  logic [6:0]       p_reg;
  logic [LEN_W-1:0] len_reg;
  chunk_t           buf_reg;
  logic             last_reg;
  logic             valid_reg;
  logic             ready_reg;

  logic [63:0]      bit_len;
  chunk_t           padded;
  logic             needs_extra;

  assign bit_len = 64'(len_reg) << 3;

  sha256_pad_mask u_pad_mask (
    .blk         (buf_reg),
    .pos         (p_reg),
    .bit_len     (bit_len),
    .len_only    (state_reg == LEN),
    .padded      (padded),
    .needs_extra (needs_extra)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= FILL;
      ret_reg   <= FILL;
      p_reg     <= '0;
      len_reg   <= '0;
      buf_reg   <= '0;
      last_reg  <= 1'b0;
      valid_reg <= 1'b0;
      ready_reg <= 1'b1;
    end else begin
      case (state_reg)
        FILL: begin
          if (in_valid) begin
            // Byte p sits at [511-8p -: 8], i.e. bit offset 8*(63-p).
            buf_reg[{~p_reg[5:0], 3'b000} +: 8] <= in_data;
            p_reg   <= p_reg + 7'd1;
            len_reg <= len_reg + 1'b1;
            if (p_reg == 7'(BLOCK_BYTES - 1)) begin
              state_reg <= EMIT;
              ret_reg   <= in_last ? PAD : FILL;
              last_reg  <= 1'b0;
              valid_reg <= 1'b1;
              ready_reg <= 1'b0;
            end else if (in_last) begin
              state_reg <= PAD;
              ready_reg <= 1'b0;
            end
          end
        end
        PAD: begin
          buf_reg   <= padded;
          last_reg  <= !needs_extra;
          ret_reg   <= needs_extra ? LEN : FILL;
          state_reg <= EMIT;
          valid_reg <= 1'b1;
        end
        LEN: begin
          buf_reg   <= padded;
          last_reg  <= 1'b1;
          ret_reg   <= FILL;
          state_reg <= EMIT;
          valid_reg <= 1'b1;
        end
        EMIT: begin
          if (chunk_ready) begin
            p_reg     <= '0;
            state_reg <= ret_reg;
            valid_reg <= 1'b0;
            ready_reg <= (ret_reg == FILL);
            if (last_reg) begin
              len_reg <= '0;
              buf_reg <= '0;
            end
          end
        end
        default: state_reg <= FILL;
      endcase
    end
  end

  assign in_ready    = ready_reg;
  assign chunk       = buf_reg;
  assign chunk_valid = valid_reg;
  assign chunk_last  = last_reg;

`ifdef SHA256_PADDER_STATS_EN
  logic [31:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (valid_reg && chunk_ready) begin
      count_reg <= count_reg + 32'd1;
    end
  end

  assign chunk_count = count_reg;
`endif

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Self-checking bench for sha256_msg_padder: directed padding cases plus random messages
// against a byte-queue padding model.
module tb_sha256_msg_padder;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [511:0] chunk;
  logic         chunk_valid;
  logic         chunk_ready;
  logic         chunk_last;
`ifdef SHA256_PADDER_STATS_EN
  logic [31:0]  chunk_count;
`endif

  sha256_msg_padder dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .chunk       (chunk),
    .chunk_valid (chunk_valid),
    .chunk_ready (chunk_ready),
    .chunk_last  (chunk_last)
`ifdef SHA256_PADDER_STATS_EN
    ,
    .chunk_count (chunk_count)
`endif
  );

  initial forever #5 clk = ~clk;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [511:0] exp_chunk_q[$];
  logic         exp_last_q[$];
  logic [7:0]   msg[$];
  int           n_hs = 0;
  logic [511:0] last_chunk = '0;
  logic         last_last  = 1'b0;
  logic         hold = 1'b0;
  logic         held = 1'b0;
  logic [511:0] held_chunk;
  logic         held_last;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  // Reference: append 0x80, zero to 56 mod 64, 8-byte big-endian bit count, slice into blocks.
  task automatic model_push();
    logic [7:0]   pad[$];
    logic [63:0]  bits;
    logic [511:0] blk;
    int           nblk;
    pad = msg;
    pad.push_back(8'h80);
    while (pad.size() % 64 != 56) pad.push_back(8'h00);
    bits = 64'(msg.size()) * 64'd8;
    for (int k = 7; k >= 0; k--) pad.push_back(bits[8*k +: 8]);
    nblk = pad.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      blk = '0;
      for (int i = 0; i < 64; i++) blk[511-8*i -: 8] = pad[b*64+i];
      exp_chunk_q.push_back(blk);
      exp_last_q.push_back(b == nblk - 1);
    end
  endtask

  task automatic make_msg(input int n, input int fill);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back((fill < 0) ? 8'($urandom) : 8'(fill));
  endtask

  task automatic make_abc();
    msg.delete();
    msg.push_back(8'h61);
    msg.push_back(8'h62);
    msg.push_back(8'h63);
  endtask

  task automatic send(input bit mark_last);
    int idx = 0;
    int budget = 0;
    bit acc;
    while (idx < msg.size()) begin
      in_data  = msg[idx];
      in_last  = mark_last && (idx == msg.size() - 1);
      in_valid = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
      budget++;
      if (budget > 5000) begin
        check_eq("send_timeout", 512'(idx), 512'(msg.size()));
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int budget = 0;
    while (exp_chunk_q.size() != 0 && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    check_eq("drain", 512'(exp_chunk_q.size()), 512'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    chunk_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      chunk_ready = hold ? 1'b0 : ($urandom_range(0, 2) != 0);
    end
  end

  // Scoreboard and stall-stability monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check_eq("stall_valid", 512'(chunk_valid), 512'd1);
        check_eq("stall_chunk", chunk, held_chunk);
        check_eq("stall_last", 512'(chunk_last), 512'(held_last));
      end
      if (chunk_valid && chunk_ready) begin
        if (exp_chunk_q.size() == 0) begin
          check_eq("spurious_chunk", 512'(exp_chunk_q.size()), 512'd1);
        end else begin
          check_eq("chunk", chunk, exp_chunk_q.pop_front());
          check_eq("chunk_last", 512'(chunk_last), 512'(exp_last_q.pop_front()));
        end
        n_hs++;
        last_chunk = chunk;
        last_last  = chunk_last;
      end
      held       = chunk_valid && !chunk_ready;
      held_chunk = chunk;
      held_last  = chunk_last;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hs0;
    int budget;
    logic [511:0] snap;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_in_ready", 512'(in_ready), 512'd1);
    check_eq("rst_chunk_valid", 512'(chunk_valid), 512'd0);
    check_eq("rst_chunk_last", 512'(chunk_last), 512'd0);
    check_eq("rst_chunk", chunk, 512'd0);
    @(posedge clk);
    #1;

    make_abc();
    model_push();
    send(1'b1);
    drain();
    check_eq("abc_block", last_chunk, {32'h61626380, 416'd0, 64'h18});
    check_eq("abc_last", 512'(last_last), 512'd1);

    make_msg(55, 0);
    model_push();
    send(1'b1);
    drain();
    check_eq("len55_marker", 512'(last_chunk[71:64]), 512'h80);
    check_eq("len55_bits", 512'(last_chunk[63:0]), 512'h1B8);

    hs0 = n_hs;
    make_msg(56, 8'h41);
    model_push();
    send(1'b1);
    drain();
    check_eq("len56_blocks", 512'(n_hs - hs0), 512'd2);
    check_eq("len56_tail", last_chunk, {448'd0, 64'h1C0});

    hs0 = n_hs;
    make_msg(64, -1);
    model_push();
    send(1'b1);
    drain();
    check_eq("len64_blocks", 512'(n_hs - hs0), 512'd2);
    check_eq("len64_tail", last_chunk, {8'h80, 440'd0, 64'h200});
    make_abc();
    model_push();
    send(1'b1);
    drain();
    check_eq("len_cleared", 512'(last_chunk[63:0]), 512'h18);

    // Backpressure: hold chunk_ready low for 10 cycles of a pending block.
    hold = 1'b1;
    make_msg(5, -1);
    model_push();
    send(1'b1);
    budget = 0;
    while (!chunk_valid && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    check_eq("hold_reached", 512'(chunk_valid), 512'd1);
    snap = chunk;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_eq("hold_in_ready", 512'(in_ready), 512'd0);
      check_eq("hold_valid", 512'(chunk_valid), 512'd1);
      check_eq("hold_chunk", chunk, snap);
    end
    hs0 = n_hs;
    @(posedge clk);
    #1;
    hold = 1'b0;
    drain();
    check_eq("hold_one_hs", 512'(n_hs - hs0), 512'd1);

    // Reset in the middle of a message discards it.
    make_msg(30, -1);
    send(1'b0);
    hs0 = n_hs;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("midrst_in_ready", 512'(in_ready), 512'd1);
    check_eq("midrst_valid", 512'(chunk_valid), 512'd0);
    repeat (5) @(negedge clk);
    check_eq("midrst_no_block", 512'(n_hs - hs0), 512'd0);
    @(posedge clk);
    #1;
    make_abc();
    model_push();
    send(1'b1);
    drain();
    check_eq("post_rst_abc", last_chunk, {32'h61626380, 416'd0, 64'h18});
`ifdef SHA256_PADDER_STATS_EN
    @(negedge clk);
    check_eq("chunk_count", 512'(chunk_count), 512'd1);
    @(posedge clk);
    #1;
`endif

    for (int m = 0; m < 20; m++) begin
      make_msg($urandom_range(1, 140), -1);
      model_push();
      send(1'b1);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
